// File: rtl/dct_pkg.sv
// Shared constants for the 8-point row IDCT: Q16.16 basis table, default widths, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dct_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF  = 16;

  // a(k)*cos(m*pi/16) in Q16.16; CA0 carries sqrt(1/8), Cm carries 0.5*cos(m*pi/16)
  localparam int CA0 = 23170;
  localparam int C1  = 32138;
  localparam int C2  = 30274;
  localparam int C3  = 27246;
  localparam int C4  = 23170;
  localparam int C5  = 18205;
  localparam int C6  = 12540;
  localparam int C7  = 6393;

  // IDCT_C[k][n] = a(k)*cos((2n+1)*k*pi/16)
  localparam logic signed [31:0] IDCT_C [8][8] = '{
    '{CA0, CA0, CA0, CA0, CA0, CA0, CA0, CA0},
    '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
    '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
    '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
    '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
    '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
    '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
    '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/idct_row_mac.sv
// Combinational 8-point row IDCT: 8 products per output, round half-up, saturate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller holds the input row stable.
module idct_row_mac
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic [8*DATA_WIDTH-1:0] x_row,
  output logic [8*DATA_WIDTH-1:0] y_row
);

  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int ACC_W  = 2*DATA_WIDTH + 3;

  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] xk;
  logic signed [DATA_WIDTH-1:0] ck;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      sh;

  // Dot product of the coefficient row with each basis column, then round and clamp
  always_comb begin
    xk    = '0;
    ck    = '0;
    prod  = '0;
    acc   = '0;
    sh    = '0;
    y_row = '0;
    for (int n = 0; n < 8; n++) begin
      acc = '0;
      for (int k = 0; k < 8; k++) begin
        xk   = signed'(x_row[k*DATA_WIDTH +: DATA_WIDTH]);
        ck   = DATA_WIDTH'(IDCT_C[k][n]);
        prod = xk * ck;
        acc  = acc + ACC_W'(prod);
      end
      sh = (acc + RND) >>> FRAC_BITS;
      if (sh > SAT_MAX) begin
        y_row[n*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
      end else if (sh < SAT_MIN) begin
        y_row[n*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
        y_row[n*DATA_WIDTH +: DATA_WIDTH] = sh[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/idct_1d_8x8_seq.sv
// Sequential 1-D IDCT over an 8x8 Q16.16 block, one row per cycle; optional IDCT_TRANSPOSE_OUT_EN writes rows as columns.
// Latency: accept edge 0, out_valid first sampled high at edge 9; one block per 10 cycles at best.
// Backpressure: out_block/out_valid held while !out_ready; in_ready only in IDLE, no overlap.
module idct_1d_8x8_seq
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [64*DATA_WIDTH-1:0] in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [64*DATA_WIDTH-1:0] out_block,
  output logic                     busy
);

  localparam int ROW_W = 8*DATA_WIDTH;

  state_t                  state_q;
  state_t                  state_d;
  logic [2:0]              row_q;
  logic [64*DATA_WIDTH-1:0] src_q;
  logic [64*DATA_WIDTH-1:0] out_q;
  logic [ROW_W-1:0]        src_row;
  logic [ROW_W-1:0]        res_row;

  assign src_row   = src_q[row_q*ROW_W +: ROW_W];
  assign out_block = out_q;

  idct_row_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .x_row (src_row),
    .y_row (res_row)
  );

  // Next state and handshake outputs; in_ready is tied to IDLE so blocks never overlap
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (row_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Row counter: parked at 0 outside CALC, wraps back to 0 after row 7
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              row_q <= 3'd0;
    else if (state_q == CALC)  row_q <= row_q + 3'd1;
    else                       row_q <= 3'd0;
  end

  // Source block is sampled only on the accept edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  src_q <= '0;
    else if (in_valid && in_ready) src_q <= in_block;
  end

  // Result rows land one per CALC cycle; untouched in DONE so backpressure holds them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else if (state_q == CALC) begin
`ifdef IDCT_TRANSPOSE_OUT_EN
      for (int n = 0; n < 8; n++) begin
        out_q[(n*8 + int'(row_q))*DATA_WIDTH +: DATA_WIDTH] <= res_row[n*DATA_WIDTH +: DATA_WIDTH];
      end
`else
      out_q[row_q*ROW_W +: ROW_W] <= res_row;
`endif
    end
  end

endmodule

// File: tb/tb_idct_1d_8x8_seq.sv
// Directed bench for idct_1d_8x8_seq: DC, zero, backpressure, saturation, rounding, reset, output layout.
// Latency: checks out_valid is first sampled high on edge 9 after the accept edge.
// Backpressure: holds out_ready low in DONE and checks the result is held.
module tb_idct_1d_8x8_seq;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2047:0] in_block;
  logic          out_valid;
  logic          out_ready;
  logic [2047:0] out_block;
  logic          busy;

  logic [2047:0] blk;
  logic [2047:0] exp_blk;
  logic [2047:0] snap;
  int            checks = 0;
  int            errors = 0;
  int            lat;
  int            ac_row [8] = '{32138, 27246, 18205, 6393, -6393, -18205, -27246, -32138};

  always #5 clk = ~clk;

  idct_1d_8x8_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_block(input string tag, input logic [2047:0] expv);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c),
            out_block[(r*8+c)*32 +: 32], expv[(r*8+c)*32 +: 32]);
  endtask

  function automatic logic [2047:0] put(input logic [2047:0] b, input int r, input int c,
                                        input logic [31:0] v);
    b[(r*8+c)*32 +: 32] = v;
    return b;
  endfunction

  task automatic send(input logic [2047:0] b);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("send_in_ready", {31'b0, in_ready}, 32'd1);
    in_block = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = {64{32'hDEADBEEF}};
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 40) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk_block("rst_out", '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: DC only -> 8.0 * sqrt(1/8) = 0x0002D410 everywhere
    blk = '0;
    for (int r = 0; r < 8; r++) blk = put(blk, r, 0, 32'h00080000);
    send(blk);
    chk("dc_busy", {31'b0, busy}, 32'd1);
    wait_out(lat);
    chk("dc_latency_edge", lat + 1, 32'd9);
    exp_blk = {64{32'h0002D410}};
    chk_block("dc", exp_blk);
    take();
    chk("dc_in_ready_after", {31'b0, in_ready}, 32'd1);

    // 2: zero block
    send('0);
    wait_out(lat);
    chk_block("zero", '0);
    take();
    chk("zero_in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("zero_out_valid_after", {31'b0, out_valid}, 32'd0);

    // 3: backpressure with a single 1.0 at X[0][1]: row 0 is the k=1 basis row
    send(put('0, 0, 1, 32'h00010000));
    wait_out(lat);
    snap = out_block;
    in_block = {64{32'h00080000}};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      chk_block($sformatf("bp_hold_%0d", i), snap);
    end
    exp_blk = '0;
    for (int c = 0; c < 8; c++) exp_blk = put(exp_blk, 0, c, ac_row[c]);
    chk_block("ac", exp_blk);
    in_valid = 1'b0;
    take();
    chk("bp_busy_after", {31'b0, busy}, 32'd0);
    chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);

    // 4: saturation both ways
    blk = '0;
    for (int c = 0; c < 8; c++) blk = put(blk, 0, c, 32'h7FFF0000);
    send(blk);
    wait_out(lat);
    chk("sat_pos", out_block[31:0], 32'h7FFFFFFF);
    take();
    blk = '0;
    for (int c = 0; c < 8; c++) blk = put(blk, 0, c, 32'h80010000);
    send(blk);
    wait_out(lat);
    chk("sat_neg", out_block[31:0], 32'h80000000);
    take();

    // 5: rounding (+-2 LSB DC) and a flat 1.0 pixel row from its DC coefficient sqrt(8)
    blk = '0;
    blk = put(blk, 0, 0, 32'h00000002);
    blk = put(blk, 1, 0, 32'hFFFFFFFE);
    blk = put(blk, 2, 0, 32'd185364);
    send(blk);
    wait_out(lat);
    for (int c = 0; c < 8; c++) begin
      int d;
      chk($sformatf("rnd_pos_%0d", c), out_block[(0*8+c)*32 +: 32], 32'h00000001);
      chk($sformatf("rnd_neg_%0d", c), out_block[(1*8+c)*32 +: 32], 32'hFFFFFFFF);
      d = int'(signed'(out_block[(2*8+c)*32 +: 32])) - 32'h00010000;
      if (d < 0) d = -d;
      chk($sformatf("roundtrip_%0d_within", c), {31'b0, (d <= 32'h8000)}, 32'd1);
    end
    take();

    // 6: reset while row counter is 4
    blk = '0;
    for (int r = 0; r < 8; r++) blk = put(blk, r, 0, 32'h00080000);
    send(blk);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    @(posedge clk); #1;
    chk("midrst_out_valid_next", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy_next",      {31'b0, busy},      32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk_block("midrst_out", '0);

    // Output layout: single DC at row 2
    send(put('0, 2, 0, 32'h00080000));
    wait_out(lat);
    chk("layout_latency_edge", lat + 1, 32'd9);
    exp_blk = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef IDCT_TRANSPOSE_OUT_EN
      exp_blk = put(exp_blk, i, 2, 32'h0002D410);
`else
      exp_blk = put(exp_blk, 2, i, 32'h0002D410);
`endif
    end
    chk_block("layout", exp_blk);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
